// File: rtl/truth_table_engine.sv
// truth_table_engine: programmable N_IN-input Boolean function unit.
// A 2^N_IN-bit truth table is shifted in serially (index 0 first) and input
// vectors are then looked up through a one-deep registered valid/ready stage.
// Optional feature macro: TTE_SWEEP_EN adds an internal 0..TT_W-1 sweep.
module truth_table_engine #(
  parameter int unsigned N_IN = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_valid_i,
  input  logic            cfg_bit_i,
  output logic            cfg_ready_o,
  output logic            cfg_done_o,
  input  logic            in_valid_i,
  input  logic [N_IN-1:0] in_data_i,
  output logic            in_ready_o,
  output logic            out_valid_o,
  output logic            out_data_o,
  input  logic            out_ready_i,
  output logic            programmed_o
`ifdef TTE_SWEEP_EN
  ,
  input  logic            sweep_start_i,
  output logic            sweep_active_o,
  output logic            out_last_o
`endif
);

  localparam int unsigned TT_W  = 1 << N_IN;
  localparam int unsigned CNT_W = (TT_W > 2) ? $clog2(TT_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e           state_q;
  logic [TT_W-1:0]  table_q;
  logic [TT_W-1:0]  shadow_q;
  logic [TT_W-1:0]  shadow_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cfg_done_q;
  logic             out_valid_q;
  logic             out_data_q;
  logic             programmed_q;

  logic             cfg_fire;
  logic             in_fire;
  logic             cnt_last;
  logic             sweep_busy;
  logic             sweep_feed;
  logic             sweep_bit;

  // Handshake readiness; input vectors win over configuration in RUN
  always_comb begin
    cfg_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: cfg_ready_o = 1'b1;
      S_RUN: begin
        in_ready_o  = (!out_valid_q || out_ready_i) && !sweep_busy;
        cfg_ready_o = !out_valid_q && !in_valid_i && !sweep_busy;
      end
      default: begin
        cfg_ready_o = 1'b0;
        in_ready_o  = 1'b0;
      end
    endcase
  end

  assign cfg_fire = cfg_valid_i && cfg_ready_o;
  assign in_fire  = in_valid_i && in_ready_o;
  assign cnt_last = (cnt_q == CNT_W'(TT_W - 1));
  // Right shift so the first bit received lands at index 0 after TT_W shifts
  assign shadow_d = {cfg_bit_i, shadow_q[TT_W-1:1]};

  // Control FSM, table commit and registered output stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      table_q      <= '0;
      shadow_q     <= '0;
      cnt_q        <= '0;
      cfg_done_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 1'b0;
      programmed_q <= 1'b0;
    end else begin
      cfg_done_q <= 1'b0;
      if (cfg_fire) begin
        shadow_q <= shadow_d;
        if (cnt_last) begin
          table_q      <= shadow_d;
          cnt_q        <= '0;
          cfg_done_q   <= 1'b1;
          programmed_q <= 1'b1;
          state_q      <= S_RUN;
        end else begin
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= S_LOAD;
        end
      end
      if (in_fire) begin
        out_valid_q <= 1'b1;
        out_data_q  <= table_q[in_data_i];
      end else if (sweep_feed) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sweep_bit;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef TTE_SWEEP_EN
  localparam int unsigned SW_W = N_IN + 1;

  logic            sweep_active_q;
  logic            out_last_q;
  logic [SW_W-1:0] sweep_idx_q;
  logic            sweep_go;

  // Index MSB set means every entry has been issued; only the drain remains
  assign sweep_busy = sweep_active_q;
  assign sweep_go   = sweep_start_i && (state_q == S_RUN) && !out_valid_q &&
                      !sweep_active_q && !in_fire && !cfg_fire;
  assign sweep_feed = sweep_active_q && !sweep_idx_q[N_IN] &&
                      (!out_valid_q || out_ready_i);
  assign sweep_bit  = table_q[sweep_idx_q[N_IN-1:0]];

  // Sweep sequencing: issue 0..TT_W-1, retire once the last result is taken
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sweep_active_q <= 1'b0;
      sweep_idx_q    <= '0;
      out_last_q     <= 1'b0;
    end else begin
      if (sweep_go) begin
        sweep_active_q <= 1'b1;
        sweep_idx_q    <= '0;
      end else if (sweep_feed) begin
        sweep_idx_q <= sweep_idx_q + SW_W'(1);
      end else if (sweep_active_q && out_valid_q && out_ready_i && out_last_q) begin
        sweep_active_q <= 1'b0;
      end
      if (sweep_feed) begin
        out_last_q <= &sweep_idx_q[N_IN-1:0];
      end else if (out_ready_i) begin
        out_last_q <= 1'b0;
      end
    end
  end

  assign sweep_active_o = sweep_active_q;
  assign out_last_o     = out_last_q;
`else
  assign sweep_busy = 1'b0;
  assign sweep_feed = 1'b0;
  assign sweep_bit  = 1'b0;
`endif

  assign cfg_done_o   = cfg_done_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign programmed_o = programmed_q;

endmodule

// File: doc/truth_table_engine.md
# truth_table_engine

Programmable N-input Boolean function unit: a truth table of 2^N_IN bits is shifted in serially, and input vectors are then evaluated against it through a one-deep registered valid/ready output stage. It replaces per-function fixed gate netlists such as the 3-input NOR/NOT designs. One instance can be reprogrammed to any function, including 0x86, without resynthesis. It sits between the stimulus generator and the circuit-scoring logic.

## Interface
- N_IN, 3, number of function inputs; legal 1..6
- TT_W, 2**N_IN, truth-table width; derived, not overridable
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  a configuration bit is offered
- cfg_bit  in  1  truth-table bit; index 0 first, index TT_W-1 last
- cfg_ready  out  1  configuration bit can be accepted
- cfg_done  out  1  one-cycle pulse when a full table is committed
- in_valid  in  1  input vector offered
- in_data  in  N_IN  input vector; bit 0 is the LSB of the table index
- in_ready  out  1  input vector can be accepted
- out_valid  out  1  result held
- out_data  out  1  table[in_data] of the accepted vector
- out_ready  in  1  downstream accepts the result
- programmed  out  1  a complete table has been committed since reset

## Operation
- States: IDLE (unprogrammed), LOAD, RUN.
- Transfers happen when valid && ready on the same edge.
- IDLE:
  - cfg_ready=1 and in_ready=0.
  - The first accepted cfg bit moves the state to LOAD.
- LOAD:
  - cfg_ready=1 and in_ready=0.
  - Bits shift into a shadow register, and a load counter (0..TT_W-1) increments on each accepted bit.
  - When bit TT_W-1 is accepted, the shadow is copied to the active table, cfg_done pulses the following cycle, programmed=1, and the state moves to RUN.
- RUN:
  - in_ready = !out_valid || out_ready.
  - An accepted vector loads out_data <= table[in_data] and sets out_valid=1.
  - out_valid clears on out_ready when no new vector is accepted.
  - cfg_ready = !out_valid && !in_valid, so input has priority.
  - An accepted cfg bit moves the state to LOAD. The active table is untouched until the new commit.
- cfg_valid while cfg_ready=0 is held off, not dropped.

## Timing
- Reset values:
  - state=IDLE, table=0, shadow=0, counter=0.
  - cfg_ready=1, cfg_done=0, in_ready=0, out_valid=0, out_data=0, programmed=0.
- Load latency: TT_W accepted bits, gaps allowed. cfg_done asserts the cycle after the last bit. in_ready can rise in that same cycle.
- Evaluation latency is 1 cycle from acceptance to out_valid. Full throughput is one vector per cycle while out_ready=1.
- Backpressure: out_data and out_valid stay stable while out_valid && !out_ready.
- Reprogram to RUN: the old table is active until the commit edge. The first vector evaluated after that uses the new table.
- rst mid-load discards the partial table. The state returns to IDLE and programmed=0.
- The counter wraps to 0 at commit and never exceeds TT_W-1.

## Configuration
- TTE_SWEEP_EN defined:
  - Adds ports sweep_start (in, 1), sweep_active (out, 1) and out_last (out, 1).
  - A sweep_start pulse in RUN with out_valid=0 starts a sweep: in_ready=0 and sweep_active=1.
  - The unit internally feeds indices 0..TT_W-1 through the evaluation path, honouring out_ready.
  - out_last=1 on index TT_W-1. sweep_active clears after that result is consumed.
  - sweep_start in IDLE, LOAD or mid-sweep is ignored.
  - cfg_ready=0 during a sweep.
  - rst aborts the sweep, and all added outputs reset to 0.
- TTE_SWEEP_EN undefined: the ports and sweep logic are absent, and behaviour is otherwise identical.

## Test plan
- Reset then check idle outputs: reset, then in_valid=1 with in_data=3'b001 -> in_ready=0 and out_valid=0 throughout; cfg_ready=1.
- Load 0x86 and evaluate all inputs:
  - Shift in bits 0,1,1,0,0,0,0,1 -> cfg_done pulses once and programmed=1.
  - Vectors 000..111 back-to-back with out_ready=1 -> outputs 0,1,1,0,0,0,0,1, one per cycle.
- Backpressure: hold out_ready=0 with vector 3'b111 in flight -> out_data=1 held and in_ready=0; release -> the next vector is accepted the same cycle.
- Reprogram and check priority:
  - In RUN, raise in_valid and cfg_valid together -> the vector is accepted first.
  - Load 0x01 -> vector 000 gives 1 and vector 111 gives 0 after cfg_done.
- Reset mid-load: assert rst after 5 of 8 bits -> state IDLE, programmed=0; a subsequent full load of 0x86 commits correctly.
- Sweep (TTE_SWEEP_EN) with table 0x86:
  - Pulse sweep_start -> 8 results 0,1,1,0,0,0,0,1 are emitted, with out_last only on the 8th.
  - Random out_ready stalls preserve the order.
